// File: rtl/ann_pkg.sv
// ann_pkg: shared sizes, memory-layout constants, state type and activation for the MAC sequencer
package ann_pkg;
    localparam int DW        = 16;
    localparam int ACC_W     = 32;
    localparam int N_IN      = 8;
    localparam int N_HID     = 16;
    localparam int N_OUT     = 4;
    localparam int AW        = 8;
    localparam int L1_BASE   = 144;
    localparam int L0_STRIDE = 9;
    localparam int L1_STRIDE = 17;
    localparam int LAST_ADDR = 211;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic signed [DW-1:0] act_sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        s = acc > 32'sd32767 ? 32'sd32767 : acc < -32'sd32768 ? -32'sd32768 : acc;
        return DW'((s >>> 1) + 32'sd128);
    endfunction
endpackage

// File: rtl/ann_mac_sequencer_if.sv
// ann_mac_sequencer_if: feature-in, score-out and weight-memory signals of the MAC sequencer
interface ann_mac_sequencer_if;
    import ann_pkg::*;
    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN*DW-1:0]   in_feat;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_OUT*DW-1:0]  out_cls;
    logic                 w_en;
    logic [AW-1:0]        w_addr;
    logic signed [DW-1:0] w_rdata;
    logic                 busy;
    modport slave (
        input  in_valid, in_feat, out_ready, w_rdata,
        output in_ready, out_valid, out_cls, w_en, w_addr, busy
    );
    modport master (
        output in_valid, in_feat, out_ready, w_rdata,
        input  in_ready, out_valid, out_cls, w_en, w_addr, busy
    );
endinterface

// File: rtl/ann_mac_unit.sv
// ann_mac_unit: shared multiply-accumulate with bias add, saturation and activation per neuron
module ann_mac_unit
    import ann_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 first,
    input  logic                 bias,
    input  logic signed [DW-1:0] op,
    input  logic signed [DW-1:0] w,
    output logic signed [DW-1:0] result
);
    logic signed [ACC_W-1:0] acc, acc_nx, prod, bias_x;

    // next accumulator value; result is live on the bias beat so the neuron is written that edge
    always_comb begin
        prod   = ACC_W'(op) * ACC_W'(w);
        bias_x = ACC_W'(w) <<< 4;
        acc_nx = bias ? acc + bias_x : first ? prod : acc + prod;
        result = act_sat_shift(acc_nx);
    end

    // accumulator register, advanced once per consumed data beat
    always_ff @(posedge clk)
        if (rst) acc <= '0;
        else if (en) acc <= acc_nx;
endmodule

// File: rtl/ann_mac_sequencer.sv
// ann_mac_sequencer: time-multiplexed single-MAC evaluation of the 8-16-4 classifier network
module ann_mac_sequencer
    import ann_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ann_mac_sequencer_if.slave bus
);
    state_t state, state_nx;
    logic signed [DW-1:0] feat   [N_IN];
    logic signed [DW-1:0] hidden [N_HID];
    logic signed [DW-1:0] obuf   [N_OUT];
    logic [4:0] iss_j, rd_j;
    logic [3:0] iss_n, rd_n;
    logic iss_l1, rd_l1, rd_en;
    logic iss_last_j, rd_bias, rd_first, rd_last, accept, out_fire;
    logic signed [DW-1:0] operand, result;

    // handshake outputs, beat decode and next state
    always_comb begin
        bus.in_ready  = state == IDLE && !rst;
        bus.out_valid = state == DONE;
        bus.busy      = state != IDLE;
        accept        = bus.in_valid && bus.in_ready;
        out_fire      = bus.out_valid && bus.out_ready;
        iss_last_j    = iss_j == (iss_l1 ? 5'(L1_STRIDE - 1) : 5'(L0_STRIDE - 1));
        rd_bias       = rd_j == (rd_l1 ? 5'(L1_STRIDE - 1) : 5'(L0_STRIDE - 1));
        rd_first      = rd_j == '0;
        rd_last       = rd_en && rd_l1 && rd_bias && rd_n == 4'(N_OUT - 1);
        operand       = rd_l1 ? hidden[rd_j[3:0]] : feat[rd_j[2:0]];
        state_nx      = state == IDLE ? (accept ? RUN : IDLE)
                      : state == RUN  ? (rd_last ? DONE : RUN)
                      : (out_fire ? IDLE : DONE);
    end

    // state register
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nx;

    // address issue: one word per cycle from accept through the last bias, tracking neuron/offset
    always_ff @(posedge clk)
        if (rst) begin
            bus.w_en   <= 1'b0;
            bus.w_addr <= '0;
            iss_j      <= '0;
            iss_n      <= '0;
            iss_l1     <= 1'b0;
        end else if (accept) begin
            bus.w_en   <= 1'b1;
            bus.w_addr <= '0;
            iss_j      <= '0;
            iss_n      <= '0;
            iss_l1     <= 1'b0;
        end else if (bus.w_en) begin
            bus.w_en   <= bus.w_addr != AW'(LAST_ADDR);
            bus.w_addr <= bus.w_addr == AW'(LAST_ADDR) ? bus.w_addr : bus.w_addr + 1'b1;
            iss_j      <= iss_last_j ? '0 : iss_j + 5'd1;
            iss_n      <= iss_n + 4'(iss_last_j);
            iss_l1     <= iss_l1 || (iss_last_j && iss_n == 4'(N_HID - 1));
        end

    // beat tags delayed one cycle to line up with the synchronous memory read data
    always_ff @(posedge clk)
        if (rst) begin
            rd_en <= 1'b0;
            rd_j  <= '0;
            rd_n  <= '0;
            rd_l1 <= 1'b0;
        end else begin
            rd_en <= bus.w_en;
            rd_j  <= iss_j;
            rd_n  <= iss_n;
            rd_l1 <= iss_l1;
        end

    ann_mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .en     (rd_en),
        .first  (rd_first),
        .bias   (rd_bias),
        .op     (operand),
        .w      (bus.w_rdata),
        .result (result)
    );

    // feature latch, hidden/output buffers; scores publish together on the final beat
    always_ff @(posedge clk)
        if (rst) begin
            feat        <= '{default: '0};
            hidden      <= '{default: '0};
            obuf        <= '{default: '0};
            bus.out_cls <= '0;
        end else begin
            if (accept)
                for (int i = 0; i < N_IN; i++) feat[i] <= bus.in_feat[i*DW +: DW];
            if (rd_en && rd_bias && !rd_l1) hidden[rd_n] <= result;
            if (rd_en && rd_bias && rd_l1) obuf[rd_n[1:0]] <= result;
            if (rd_last) bus.out_cls <= {result, obuf[2], obuf[1], obuf[0]};
        end
endmodule

// File: tb/tb_ann_mac_sequencer.sv
// tb_ann_mac_sequencer: directed checks of the MAC sequencer against hand values and a network model
module tb_ann_mac_sequencer;
    import ann_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] mem [212];
    int checks = 0;
    int errors = 0;

    ann_mac_sequencer_if bus();
    ann_mac_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.w_en) bus.w_rdata <= mem[bus.w_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int w0, input int b0, input int w1, input int b1);
        for (int a = 0; a < 212; a++)
            mem[a] = a < 144 ? 16'(a % 9 == 8 ? b0 : w0) : 16'((a - 144) % 17 == 16 ? b1 : w1);
    endtask

    task automatic load_trained();
        for (int a = 0; a < 212; a++)
            if (a < 144) mem[a] = a % 9 == 8 ? 16'(((a * 13) % 41) - 20) : 16'(((a * 37 + 11) % 41) - 20);
            else mem[a] = (a - 144) % 17 == 16 ? 16'(((a * 13) % 41) - 20) : 16'(((a * 3) % 7) - 3);
    endtask

    function automatic int act(input int acc);
        int s;
        s = acc > 32767 ? 32767 : acc < -32768 ? -32768 : acc;
        return (s >>> 1) + 128;
    endfunction

    function automatic logic [63:0] golden(input logic [127:0] f);
        int h [16];
        int acc;
        logic [63:0] o;
        for (int i = 0; i < 16; i++) begin
            acc = int'(mem[9*i+8]) * 16;
            for (int j = 0; j < 8; j++) acc += int'($signed(f[16*j +: 16])) * int'(mem[9*i+j]);
            h[i] = act(acc);
        end
        for (int k = 0; k < 4; k++) begin
            acc = int'(mem[144+17*k+16]) * 16;
            for (int j = 0; j < 16; j++) acc += h[j] * int'(mem[144+17*k+j]);
            o[16*k +: 16] = 16'(act(acc));
        end
        return o;
    endfunction

    task automatic accept(input logic [127:0] f, input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " in_ready"}, bus.in_ready, 1);
        bus.in_feat = f;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_feat = ~f;
        check({tag, " busy"}, bus.busy, 1);
    endtask

    task automatic track(input string tag);
        int k, en;
        bit addr_ok, rdy_lo;
        k = 0;
        en = 0;
        addr_ok = 1'b1;
        rdy_lo = 1'b1;
        while (!bus.out_valid && k < 400) begin
            if (bus.w_en) begin
                addr_ok &= bus.w_addr == 8'(en);
                en++;
            end
            rdy_lo &= !bus.in_ready;
            @(posedge clk); #1;
            k++;
        end
        check({tag, " latency"}, k, 213);
        check({tag, " w_en cycles"}, en, 212);
        check({tag, " addr seq"}, addr_ok, 1);
        check({tag, " in_ready low"}, rdy_lo, 1);
    endtask

    task automatic check_out(input string tag, input logic [63:0] exp);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s o%0d", tag, i), $signed(bus.out_cls[16*i +: 16]), $signed(exp[16*i +: 16]));
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid drop"}, bus.out_valid, 0);
        check({tag, " idle ready"}, bus.in_ready, 1);
        check({tag, " busy drop"}, bus.busy, 0);
    endtask

    initial begin
        logic [127:0] f6;
        bit stable;
        bus.in_valid = 1'b0;
        bus.in_feat = '0;
        bus.out_ready = 1'b0;
        load(1, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", bus.in_ready, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_cls", bus.out_cls, 0);
        check("rst w_en", bus.w_en, 0);
        check("rst w_addr", bus.w_addr, 0);
        check("rst busy", bus.busy, 0);
        rst = 1'b0;
        #1;

        accept({8{16'sd1}}, "t1");
        track("t1");
        check_out("t1", {4{16'sd1184}});
        release_out("t1");

        load(1000, 0, 1, 0);
        accept({8{16'sd1000}}, "t2");
        track("t2");
        check_out("t2", {4{16'sd16511}});
        release_out("t2");

        accept({8{-16'sd1000}}, "t3");
        track("t3");
        check_out("t3", {4{-16'sd16256}});
        release_out("t3");

        load(1, 0, 1, 0);
        accept({8{16'sd2}}, "t5");
        track("t5");
        check_out("t5a", {4{16'sd1216}});
        bus.in_valid = 1'b1;
        bus.in_feat = {8{16'sd1}};
        stable = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            stable &= bus.out_cls === {4{16'sd1216}} && bus.out_valid && !bus.in_ready && bus.busy;
        end
        check("t5 hold", stable, 1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("t5 out_valid drop", bus.out_valid, 0);
        check("t5 no accept", bus.busy, 0);
        check("t5 idle ready", bus.in_ready, 1);
        check_out("t5 keep", {4{16'sd1216}});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_feat = '0;
        check("t5 accept busy", bus.busy, 1);
        check("t5 accept w_en", bus.w_en, 1);
        check("t5 accept w_addr", bus.w_addr, 0);
        track("t5b");
        check_out("t5b", {4{16'sd1184}});
        release_out("t5b");

        accept({8{16'sd1}}, "t6");
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6 rst in_ready", bus.in_ready, 0);
        check("t6 rst out_valid", bus.out_valid, 0);
        check("t6 rst out_cls", bus.out_cls, 0);
        check("t6 rst w_en", bus.w_en, 0);
        check("t6 rst w_addr", bus.w_addr, 0);
        check("t6 rst busy", bus.busy, 0);
        rst = 1'b0;
        #1;
        check("t6 ready after rst", bus.in_ready, 1);
        load_trained();
        f6 = {16'sd450, -16'sd320, 16'sd77, -16'sd500, 16'sd210, 16'sd399, -16'sd145, 16'sd18};
        accept(f6, "t6");
        track("t6");
        check_out("t6", golden(f6));
        release_out("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
